// File: rtl/slot_demux_decoder_pkg.sv
// Shared constants and reference functions for the rotating-slot XNOR-chain link.
package slot_demux_decoder_pkg;

    localparam int NSLOT  = 5;
    localparam int SLOT_W = 3;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam slot_t SLOT_LAST = slot_t'(NSLOT - 1);

    // Inverse of the XNOR chain: d[0]=e[0], d[j]=e[j]^~d[j-1] over the low wd bits.
    function automatic logic [31:0] chain_decode(input logic [31:0] e, input int wd);
        logic [31:0] d;
        d    = '0;
        d[0] = e[0];
        for (int j = 1; j < 32; j++) begin
            if (j < wd) d[j] = e[j] ^ ~d[j-1];
        end
        return d;
    endfunction

    // Forward XNOR chain used on the encoder side: e[0]=d[0], e[j]=d[j]^~d[j-1].
    function automatic logic [31:0] chain_encode(input logic [31:0] d, input int wd);
        logic [31:0] e;
        e    = '0;
        e[0] = d[0];
        for (int j = 1; j < 32; j++) begin
            if (j < wd) e[j] = d[j] ^ ~d[j-1];
        end
        return e;
    endfunction

endpackage

// File: rtl/slot_demux_decoder_xnor_chain_decode.sv
// Combinational ripple inverse of the XNOR chain, one link per bit.
module xnor_chain_decode #(
    parameter int WD = 4
) (
    input  logic [WD-1:0] i_enc,
    output logic [WD-1:0] o_dec
);

    // Each link holds its own bit so the chain never feeds back into one vector.
    for (genvar j = 0; j < WD; j++) begin : g_stage
        logic w_bit;
        if (j == 0) begin : g_first
            assign w_bit = i_enc[0];
        end else begin : g_link
            assign w_bit = i_enc[j] ^ ~g_stage[j-1].w_bit;
        end
        assign o_dec[j] = w_bit;
    end

endmodule

// File: rtl/slot_demux_decoder.sv
// Receive side of the 5-slot rotating link: slot tracking, XNOR-chain decode,
// odd-slot un-inversion and demux into five registered lanes.
module slot_demux_decoder
    import slot_demux_decoder_pkg::*;
#(
    parameter int WD = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    input  logic [WD-1:0]     i_in_data,
    input  logic              i_in_sync,
    output logic [WD-1:0]     o_out0,
    output logic [WD-1:0]     o_out1,
    output logic [WD-1:0]     o_out2,
    output logic [WD-1:0]     o_out3,
    output logic [WD-1:0]     o_out4,
    output logic [NSLOT-1:0]  o_out_upd,
    output logic              o_frame_done,
    output logic [SLOT_W-1:0] o_slot
);

    slot_t             r_slot;
    slot_t             w_beat_slot;
    slot_t             w_next_slot;

    logic              r_s1_valid;
    logic [WD-1:0]     r_s1_data;
    slot_t             r_s1_slot;

    logic [WD-1:0]     w_dec;
    logic [WD-1:0]     w_lane;

    logic [WD-1:0]     r_out [NSLOT];
    logic [NSLOT-1:0]  r_upd;
    logic              r_frame_done;

    // Slot taken by the current beat and the slot that follows it.
    // NOTE: every output of an always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        w_beat_slot = i_in_sync ? slot_t'(0) : r_slot;
        w_next_slot = (w_beat_slot == SLOT_LAST) ? slot_t'(0) : slot_t'(w_beat_slot + slot_t'(1));
    end

    // Stage 1: capture the encoded word with its slot; advance the slot counter per beat.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_slot     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_slot  <= '0;
        end else begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_s1_data <= i_in_data;
                r_s1_slot <= w_beat_slot;
                r_slot    <= w_next_slot;
            end
        end
    end

    xnor_chain_decode #(.WD(WD)) u_decode (
        .i_enc (r_s1_data),
        .o_dec (w_dec)
    );

    // Odd slots travel inverted on the link; slots are 0..4 so bit 0 marks 1 and 3.
    assign w_lane = r_s1_slot[0] ? ~w_dec : w_dec;

    // Stage 2: write the decoded word into its lane and raise the per-lane and frame pulses.
    // NOTE: the five lane registers are few and externally visible, so they are reset like any other flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int n = 0; n < NSLOT; n++) r_out[n] <= '0;
            r_upd        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_upd        <= '0;
            r_frame_done <= 1'b0;
            if (r_s1_valid) begin
                for (int n = 0; n < NSLOT; n++) begin
                    if (r_s1_slot == slot_t'(n)) begin
                        r_out[n] <= w_lane;
                        r_upd[n] <= 1'b1;
                    end
                end
                r_frame_done <= (r_s1_slot == SLOT_LAST);
            end
        end
    end

    assign o_out0       = r_out[0];
    assign o_out1       = r_out[1];
    assign o_out2       = r_out[2];
    assign o_out3       = r_out[3];
    assign o_out4       = r_out[4];
    assign o_out_upd    = r_upd;
    assign o_frame_done = r_frame_done;
    assign o_slot       = r_slot;

endmodule
